// File: rtl/hazard_stall_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: PC/IF-ID write enables,
// IF/ID flush, ID/EX bubble, mult/div occupancy tracking and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             ex_br_taken,
  input  logic             ext_stall,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic [15:0]      stall_cnt
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

  // Which of the four mutually exclusive pipeline actions is taken this cycle.
  typedef enum logic [1:0] {
    SEL_FREEZE,
    SEL_FLUSH,
    SEL_STALL,
    SEL_RUN
  } sel_e;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic mdh;
  logic md_busy_int;
  sel_e sel;

  logic ctrl_pc_wr, ctrl_ir_wr, ctrl_flush, ctrl_bubble;

  assign md_busy_int = (md_cnt_q != 4'd0);

  // Hazard detection and action selection; priority order is freeze > flush > stall > run.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lu  = 1'b0;
    mdh = 1'b0;
    sel = SEL_RUN;

    lu  = ex_memread && (ex_rd != '0) &&
          ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    mdh = md_busy_int && (id_md_start || id_md_read);

    if (ext_stall)        sel = SEL_FREEZE;
    else if (ex_br_taken) sel = SEL_FLUSH;
    else if (lu || mdh)   sel = SEL_STALL;
    else                  sel = SEL_RUN;
  end

  always_comb begin
    ctrl_pc_wr  = 1'b0;
    ctrl_ir_wr  = 1'b0;
    ctrl_flush  = 1'b0;
    ctrl_bubble = 1'b0;
    unique case (sel)
      SEL_FREEZE: ;
      SEL_FLUSH: begin
        ctrl_pc_wr  = 1'b1;
        ctrl_ir_wr  = 1'b1;
        ctrl_flush  = 1'b1;
        ctrl_bubble = 1'b1;
      end
      SEL_STALL: ctrl_bubble = 1'b1;
      SEL_RUN: begin
        ctrl_pc_wr = 1'b1;
        ctrl_ir_wr = 1'b1;
      end
      default: ;
    endcase
  end

  // Controls are held inactive while reset is asserted, independent of the inputs.
  assign pc_wr       = rst && ctrl_pc_wr;
  assign ir_wr       = rst && ctrl_ir_wr;
  assign ifid_flush  = rst && ctrl_flush;
  assign idex_bubble = rst && ctrl_bubble;
  assign md_busy     = rst && md_busy_int;
  assign stall_cnt   = stall_cnt_q;

  // The mult/div unit only issues when the instruction actually leaves ID; it freezes with ext_stall.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (id_md_start && (sel == SEL_RUN))
      md_cnt_d = MD_LOAD;
    else if (!ext_stall && md_busy_int)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl_pc_wr && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: state flops use non-blocking assignments and clear asynchronously on reset low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by random
// stimulus, all compared against a rule-level reference model.
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 4;
  localparam int REG_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_use_rs, id_use_rt, ex_memread;
  logic             id_md_start, id_md_read, ex_br_taken, ext_stall;
  logic             pc_wr, ir_wr, ifid_flush, idex_bubble, md_busy;
  logic [15:0]      stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state: cycles of mult/div occupancy left, and stall cycles seen.
  int md_rem  = 0;
  int stall_m = 0;

  hazard_stall_ctrl #(.MD_LAT(MD_LAT), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
    id_md_start = 1'b0; id_md_read = 1'b0; ex_br_taken = 1'b0; ext_stall = 1'b0;
  endtask

  // Called just after a rising edge with inputs already applied: check this cycle,
  // then advance one clock and update the reference model.
  task automatic step(input string tag);
    bit lu, mdh, busy, issue;
    bit e_pc, e_ir, e_fl, e_bu;
    #2;
    busy = (md_rem > 0);
    lu   = ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    mdh  = busy && (id_md_start || id_md_read);
    if (ext_stall)        {e_pc, e_ir, e_fl, e_bu} = 4'b0000;
    else if (ex_br_taken) {e_pc, e_ir, e_fl, e_bu} = 4'b1111;
    else if (lu || mdh)   {e_pc, e_ir, e_fl, e_bu} = 4'b0001;
    else                  {e_pc, e_ir, e_fl, e_bu} = 4'b1100;
    issue = id_md_start && !ext_stall && !ex_br_taken && !lu && !mdh;

    check({tag, ".pc_wr"},       32'(pc_wr),       32'(e_pc));
    check({tag, ".ir_wr"},       32'(ir_wr),       32'(e_ir));
    check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bu));
    check({tag, ".md_busy"},     32'(md_busy),     32'(busy));
    check({tag, ".stall_cnt"},   32'(stall_cnt),   32'(stall_m));

    @(posedge clk);
    if (issue)                      md_rem = MD_LAT;
    else if (!ext_stall && busy)    md_rem = md_rem - 1;
    if (!e_pc && stall_m < 16'hFFFF) stall_m = stall_m + 1;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    check("reset.pc_wr",     32'(pc_wr),     32'd0);
    check("reset.ir_wr",     32'(ir_wr),     32'd0);
    check("reset.md_busy",   32'(md_busy),   32'd0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    step("idle");

    // Load-use on rs, then the dependent instruction proceeds.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    step("lu_rs");
    idle();
    step("lu_after");

    // $zero destination and an unused operand never stall.
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    step("lu_zero");
    idle();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
    step("lu_unused_rt");
    id_use_rt = 1'b1;
    step("lu_rt");
    idle();

    // Taken branch overrides a simultaneous load-use.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; ex_br_taken = 1'b1;
    step("br_over_lu");
    idle();

    // mult followed by mfhi: MD_LAT stall cycles, then mfhi advances.
    id_md_start = 1'b1;
    step("md_issue");
    idle();
    id_md_read = 1'b1;
    for (int i = 0; i <= MD_LAT; i++) step($sformatf("md_read%0d", i));
    idle();

    // Freeze with a pending branch and md_cnt=2, then the flush fires.
    id_md_start = 1'b1;
    step("md_issue2");
    idle();
    step("md_dec_a");
    step("md_dec_b");
    ext_stall = 1'b1; ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("freeze%0d", i));
    ext_stall = 1'b0;
    step("freeze_release_flush");
    idle();
    step("post_flush");

    // Asynchronous reset in the middle of a mult/div occupancy window.
    id_md_start = 1'b1;
    step("md_issue3");
    idle();
    #2 rst = 1'b0;
    #1;
    check("midreset.pc_wr",       32'(pc_wr),       32'd0);
    check("midreset.ir_wr",       32'(ir_wr),       32'd0);
    check("midreset.ifid_flush",  32'(ifid_flush),  32'd0);
    check("midreset.idex_bubble", 32'(idex_bubble), 32'd0);
    check("midreset.md_busy",     32'(md_busy),     32'd0);
    check("midreset.stall_cnt",   32'(stall_cnt),   32'd0);
    md_rem  = 0;
    stall_m = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step("post_reset");

    // Random traffic with small register ranges so hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      id_rs       = REG_W'($urandom_range(0, 3));
      id_rt       = REG_W'($urandom_range(0, 3));
      ex_rd       = REG_W'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      id_md_start = ($urandom_range(0, 4) == 0);
      id_md_read  = ($urandom_range(0, 4) == 0);
      ex_br_taken = ($urandom_range(0, 6) == 0);
      ext_stall   = ($urandom_range(0, 6) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage CPU. It drives the PC write enable and the IF/ID instruction-register write enable (IRWr). It also drives the IF/ID flush (a NOP mux in front of the IF/ID register) and the ID/EX bubble insert. It resolves load-use hazards, taken branches, external memory stalls and multi-cycle mult/div occupancy, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LAT, 4, cycles the mult/div unit stays busy after a mult/div instruction issues from ID (1..15).
REG_W, 5, register-specifier width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active low.
id_rs  in  REG_W  rs field of the instruction in ID.
id_rt  in  REG_W  rt field of the instruction in ID.
id_use_rs  in  1  ID instruction reads rs.
id_use_rt  in  1  ID instruction reads rt.
ex_rd  in  REG_W  destination register of the instruction in EX.
ex_memread  in  1  EX instruction is a load.
id_md_start  in  1  ID instruction is mult/div.
id_md_read  in  1  ID instruction is mfhi/mflo.
ex_br_taken  in  1  branch/jump in EX resolved taken.
ext_stall  in  1  instruction/data memory not ready.
pc_wr  out  1  PC register write enable.
ir_wr  out  1  IF/ID (IRWr) write enable.
ifid_flush  out  1  force NOP into IF/ID on this write.
idex_bubble  out  1  force NOP into ID/EX.
md_busy  out  1  mult/div unit occupied.
stall_cnt  out  16  saturating count of cycles with pc_wr=0.

Behaviour:
- Reset: rst low asynchronously clears md_cnt to 0 and stall_cnt to 0. While rst is low, pc_wr, ir_wr, ifid_flush, idex_bubble and md_busy are forced to 0.
- State: md_cnt (4-bit down-counter) and stall_cnt. Controls are combinational from the current inputs and registered md_cnt (same-cycle response); md_busy = (md_cnt != 0).
- Hazard terms:
  - lu = ex_memread & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
  - mdh = md_busy & (id_md_start | id_md_read).
- Priority, highest first, exactly one case per cycle:
  1. ext_stall=1: pc_wr=0, ir_wr=0, ifid_flush=0, idex_bubble=0. The whole front end freezes; a taken branch stays in EX and is honoured after the stall.
  2. ex_br_taken=1: pc_wr=1, ir_wr=1, ifid_flush=1, idex_bubble=1. This kills the wrong-path IF and ID instructions and overrides lu/mdh.
  3. lu | mdh: pc_wr=0, ir_wr=0, ifid_flush=0, idex_bubble=1.
  4. Otherwise: pc_wr=1, ir_wr=1, ifid_flush=0, idex_bubble=0.
- md_cnt update at each rising clk:
  - issue = id_md_start & case 4 selected. On issue, load md_cnt = MD_LAT.
  - Else if ext_stall=0 and md_cnt != 0, decrement.
  - Else hold (the mult/div unit freezes with the pipeline).
- mdh stalls repeat every cycle until md_cnt reaches 0. A new mult/div issues in the first cycle md_busy=0, i.e. a back-to-back pair is separated by exactly MD_LAT stall cycles.
- stall_cnt: increments by 1 at each rising clk where pc_wr=0 (rst high); saturates at 16'hFFFF and never wraps.
- Reset asserted mid-stall or mid-mult/div: the counter clears immediately. After release, the first cycle is case 4 unless inputs dictate otherwise.
- Register 0 is never a hazard source (ex_rd=0 never stalls).

Test Plan:
- Load-use stall: ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 for 1 cycle -> that cycle pc_wr=0, ir_wr=0, idex_bubble=1; next cycle (ex_memread=0) pc_wr=ir_wr=1; stall_cnt increments 0->1.
- $zero and unused operand: ex_memread=1, ex_rd=0, id_rs=0, id_use_rs=1 -> no stall. Separately ex_rd=7, id_rt=7, id_use_rt=0 -> no stall.
- Branch over load-use: ex_br_taken=1 together with an active lu -> pc_wr=1, ir_wr=1, ifid_flush=1, idex_bubble=1; stall_cnt unchanged.
- ext_stall freeze: ext_stall=1 for 3 cycles with ex_br_taken=1 and md_cnt=2 -> all four controls 0 for 3 cycles, md_cnt stays 2, stall_cnt +3. On the cycle ext_stall drops, flush fires.
- Mult/div spacing with MD_LAT=4: mult issues, then the next ID instruction is mfhi -> md_busy=1 and 4 stall cycles with idex_bubble=1; mfhi advances in cycle 5 with md_busy=0.
- Reset mid-operation: md_cnt=3 and stall_cnt=10, drop rst asynchronously between edges -> md_busy=0, stall_cnt=0 and all controls 0 immediately. After release with idle inputs: pc_wr=ir_wr=1.
